dyn_reconf_drp: RTL and testbench
=================================

// Module: dyn_reconf_drp
// PURPOSE
//  DRP (dynamic reconfiguration port) register file for the PLL/MMCM simulation model.
//  Holds the 23 16-bit configuration registers: clock dividers, lock, filter and power.
//  Serves 16-bit reads and writes over the DCLK-domain DRP handshake.
//  Drives each register continuously to the PLL core logic.
// PARAMETERS
//  None. Widths are fixed by the DRP protocol: 7-bit address, 16-bit data.
// PORTS
//  DCLK        in   1   DRP clock; all state changes on its rising edge
//  RST         in   1   asynchronous, active-low reset (0 = reset asserted)
//  PWRDWN      in   1   power-down; 1 blocks new DRP transactions
//  DADDR       in   7   register address
//  DEN         in   1   transaction enable, sampled each rising edge
//  DWE         in   1   1 = write, 0 = read (qualified by DEN)
//  DI          in   16  write data
//  DO          out  16  read data
//  DRDY        out  1   ready flag: 1 = idle/ready, 0 = transaction in progress
//  ClkReg1_0..6, ClkReg1_FB, ClkReg2_0..6, ClkReg2_FB  out 16  clock divider registers
//  DivReg  out 16 | LockReg1..3  out 16 | FiltReg1..2  out 16 | PowerReg  out 16
// BEHAVIOUR
//  Reset (RST=0, asynchronous):
//   - all registers = 16'h0000; DO = 16'h0000; DRDY = 0.
//  Register map (other addresses are unmapped):
//   ClkReg1_5/2_5 06/07, ClkReg1_0/2_0 08/09, ClkReg1_1/2_1 0A/0B,
//   ClkReg1_2/2_2 0C/0D, ClkReg1_3/2_3 0E/0F, ClkReg1_4/2_4 10/11,
//   ClkReg1_6/2_6 12/13, ClkReg1_FB/2_FB 14/15, DivReg 16,
//   LockReg1..3 18/19/1A, PowerReg 28, FiltReg1/2 4E/4F.
//  Idle:
//   - first rising edge after reset release with DEN=0 and PWRDWN=0 sets DRDY=1.
//  Write (edge where DEN=1, DWE=1):
//   - mapped register <= DI on that edge; DO unchanged.
//  Read (edge where DEN=1, DWE=0):
//   - DO <= register[DADDR] on that edge.
//   - a write and a read of the same address on consecutive edges returns the new data.
//  DRDY:
//   - 0 from the edge after DEN is sampled high, and held 0 while DEN stays 1.
//   - returns to 1 on the first edge with DEN=0.
//   - a DEN held high repeats the access on every edge.
//  Unmapped address:
//   - write is ignored; read gives DO = 16'h0000.
//   - DRDY handshake is unchanged.
//  PWRDWN=1:
//   - DEN is ignored and DRDY is forced to 0.
//   - register contents and DO are retained.
//  Reset mid-transaction: aborts immediately; all outputs take reset values.
// CONFIGURATION
//  DYN_RECONF_ADDR_WARN_EN:
//   - defined: any DEN access to an unmapped address prints a $display warning
//     with $time, address and R/W; this is simulation-only code.
//   - undefined: no messages; functional behaviour is identical.
// STRUCTURE
//  Package dyn_reconf_pkg holds:
//   - localparam address constants, e.g. ADDR_CLKREG1_0 = 7'h08;
//   - data/address width constants (16, 7).
//  No sub-module: a single always block for the register file plus the address decode is enough.
// TESTING
//  1. RST=0 for 2 cycles -> DO==16'h0000, DRDY==0, all registers 0.
//  2. Release RST, DEN=0, wait 1 cycle -> DRDY==1.
//  3. DADDR=7'h08, DEN=1, DWE=1, DI=16'h9999 for 1 cycle -> DRDY==0, ClkReg1_0==16'h9999.
//  4. DEN=0, DWE=0 for 1 cycle -> DRDY==1; then DEN=1 read of 08 -> DRDY==0, DO==16'h9999.
//  5. Write 16'h1234 to 7'h7F, then read 7'h7F -> DO==16'h0000, no register changed;
//     with DYN_RECONF_ADDR_WARN_EN, 2 warnings are printed.
//  6. PWRDWN=1, DEN=1, DWE=1, DADDR=7'h28, DI=16'hFFFF -> DRDY==0, PowerReg==16'h0000.

Source files
------------

// File: rtl/dyn_reconf_pkg.sv
// Shared widths, DRP register map and address decode for the dyn_reconf_drp register file.
// Address map follows the PLL/MMCM DRP layout: 23 x 16-bit configuration registers.
package dyn_reconf_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 7;
    localparam int NUM_REGS = 23;

    localparam logic [ADDR_W-1:0] ADDR_CLKREG1_5  = 7'h06;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG2_5  = 7'h07;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG1_0  = 7'h08;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG2_0  = 7'h09;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG1_1  = 7'h0A;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG2_1  = 7'h0B;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG1_2  = 7'h0C;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG2_2  = 7'h0D;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG1_3  = 7'h0E;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG2_3  = 7'h0F;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG1_4  = 7'h10;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG2_4  = 7'h11;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG1_6  = 7'h12;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG2_6  = 7'h13;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG1_FB = 7'h14;
    localparam logic [ADDR_W-1:0] ADDR_CLKREG2_FB = 7'h15;
    localparam logic [ADDR_W-1:0] ADDR_DIVREG     = 7'h16;
    localparam logic [ADDR_W-1:0] ADDR_LOCKREG1   = 7'h18;
    localparam logic [ADDR_W-1:0] ADDR_LOCKREG2   = 7'h19;
    localparam logic [ADDR_W-1:0] ADDR_LOCKREG3   = 7'h1A;
    localparam logic [ADDR_W-1:0] ADDR_POWERREG   = 7'h28;
    localparam logic [ADDR_W-1:0] ADDR_FILTREG1   = 7'h4E;
    localparam logic [ADDR_W-1:0] ADDR_FILTREG2   = 7'h4F;

    typedef struct packed {
        logic       hit;
        logic [4:0] idx;
    } reg_sel_t;

    // Maps a DRP address onto a storage slot; hit=0 marks an unmapped address.
    function automatic reg_sel_t decode_addr(input logic [ADDR_W-1:0] addr);
        reg_sel_t sel;
        sel.hit = 1'b1;
        sel.idx = 5'd0;
        case (addr)
            ADDR_CLKREG1_5:  sel.idx = 5'd0;
            ADDR_CLKREG2_5:  sel.idx = 5'd1;
            ADDR_CLKREG1_0:  sel.idx = 5'd2;
            ADDR_CLKREG2_0:  sel.idx = 5'd3;
            ADDR_CLKREG1_1:  sel.idx = 5'd4;
            ADDR_CLKREG2_1:  sel.idx = 5'd5;
            ADDR_CLKREG1_2:  sel.idx = 5'd6;
            ADDR_CLKREG2_2:  sel.idx = 5'd7;
            ADDR_CLKREG1_3:  sel.idx = 5'd8;
            ADDR_CLKREG2_3:  sel.idx = 5'd9;
            ADDR_CLKREG1_4:  sel.idx = 5'd10;
            ADDR_CLKREG2_4:  sel.idx = 5'd11;
            ADDR_CLKREG1_6:  sel.idx = 5'd12;
            ADDR_CLKREG2_6:  sel.idx = 5'd13;
            ADDR_CLKREG1_FB: sel.idx = 5'd14;
            ADDR_CLKREG2_FB: sel.idx = 5'd15;
            ADDR_DIVREG:     sel.idx = 5'd16;
            ADDR_LOCKREG1:   sel.idx = 5'd17;
            ADDR_LOCKREG2:   sel.idx = 5'd18;
            ADDR_LOCKREG3:   sel.idx = 5'd19;
            ADDR_POWERREG:   sel.idx = 5'd20;
            ADDR_FILTREG1:   sel.idx = 5'd21;
            ADDR_FILTREG2:   sel.idx = 5'd22;
            default: begin
                sel.hit = 1'b0;
                sel.idx = 5'd0;
            end
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dyn_reconf_if.sv
// DRP handshake bundle: address, enable, write-enable, data in/out and ready.
interface dyn_reconf_if;
    import dyn_reconf_pkg::*;

    logic [ADDR_W-1:0] DADDR;
    logic              DEN;
    logic              DWE;
    logic [DATA_W-1:0] DI;
    logic [DATA_W-1:0] DO;
    logic              DRDY;

    modport master (output DADDR, DEN, DWE, DI, input DO, DRDY);
    modport slave  (input DADDR, DEN, DWE, DI, output DO, DRDY);
endinterface

// File: rtl/dyn_reconf_drp.sv
// DRP register file for the PLL/MMCM model; registers drive the core continuously.
// Optional DYN_RECONF_ADDR_WARN_EN: simulation notice on unmapped-address accesses.
module dyn_reconf_drp
    import dyn_reconf_pkg::*;
(
    input  logic              DCLK,
    input  logic              RST,
    input  logic              PWRDWN,
    dyn_reconf_if.slave       drp,
    output logic [DATA_W-1:0] ClkReg1_0,
    output logic [DATA_W-1:0] ClkReg1_1,
    output logic [DATA_W-1:0] ClkReg1_2,
    output logic [DATA_W-1:0] ClkReg1_3,
    output logic [DATA_W-1:0] ClkReg1_4,
    output logic [DATA_W-1:0] ClkReg1_5,
    output logic [DATA_W-1:0] ClkReg1_6,
    output logic [DATA_W-1:0] ClkReg1_FB,
    output logic [DATA_W-1:0] ClkReg2_0,
    output logic [DATA_W-1:0] ClkReg2_1,
    output logic [DATA_W-1:0] ClkReg2_2,
    output logic [DATA_W-1:0] ClkReg2_3,
    output logic [DATA_W-1:0] ClkReg2_4,
    output logic [DATA_W-1:0] ClkReg2_5,
    output logic [DATA_W-1:0] ClkReg2_6,
    output logic [DATA_W-1:0] ClkReg2_FB,
    output logic [DATA_W-1:0] DivReg,
    output logic [DATA_W-1:0] LockReg1,
    output logic [DATA_W-1:0] LockReg2,
    output logic [DATA_W-1:0] LockReg3,
    output logic [DATA_W-1:0] FiltReg1,
    output logic [DATA_W-1:0] FiltReg2,
    output logic [DATA_W-1:0] PowerReg
);

    logic [DATA_W-1:0] regs_r [0:NUM_REGS-1];
    logic [DATA_W-1:0] do_r;
    logic              drdy_r;
    reg_sel_t          sel_s;

    // Address decode of the current DRP address
    always_comb begin
        sel_s = decode_addr(drp.DADDR);
    end

    // Register file, read data and ready flag; power-down freezes everything but DRDY
    always_ff @(posedge DCLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            do_r   <= {DATA_W{1'b0}};
            drdy_r <= 1'b0;
        end else if (PWRDWN) begin
            drdy_r <= 1'b0;
        end else if (drp.DEN) begin
            drdy_r <= 1'b0;
            if (drp.DWE) begin
                if (sel_s.hit) begin
                    regs_r[sel_s.idx] <= drp.DI;
                end
            end else begin
                do_r <= sel_s.hit ? regs_r[sel_s.idx] : {DATA_W{1'b0}};
            end
        end else begin
            drdy_r <= 1'b1;
        end
    end

`ifdef DYN_RECONF_ADDR_WARN_EN
    // Simulation-only notice for accepted accesses outside the register map
    always @(posedge DCLK) begin
        if (RST && !PWRDWN && drp.DEN && !sel_s.hit) begin
            $display("%0t dyn_reconf_drp warning: unmapped %s at address 7'h%02h",
                     $time, drp.DWE ? "write" : "read", drp.DADDR);
        end
    end
`else
`endif

    assign drp.DO     = do_r;
    assign drp.DRDY   = drdy_r;

    assign ClkReg1_5  = regs_r[0];
    assign ClkReg2_5  = regs_r[1];
    assign ClkReg1_0  = regs_r[2];
    assign ClkReg2_0  = regs_r[3];
    assign ClkReg1_1  = regs_r[4];
    assign ClkReg2_1  = regs_r[5];
    assign ClkReg1_2  = regs_r[6];
    assign ClkReg2_2  = regs_r[7];
    assign ClkReg1_3  = regs_r[8];
    assign ClkReg2_3  = regs_r[9];
    assign ClkReg1_4  = regs_r[10];
    assign ClkReg2_4  = regs_r[11];
    assign ClkReg1_6  = regs_r[12];
    assign ClkReg2_6  = regs_r[13];
    assign ClkReg1_FB = regs_r[14];
    assign ClkReg2_FB = regs_r[15];
    assign DivReg     = regs_r[16];
    assign LockReg1   = regs_r[17];
    assign LockReg2   = regs_r[18];
    assign LockReg3   = regs_r[19];
    assign PowerReg   = regs_r[20];
    assign FiltReg1   = regs_r[21];
    assign FiltReg2   = regs_r[22];

endmodule

// File: tb/tb_dyn_reconf_drp.sv
// Self-checking bench for dyn_reconf_drp: model-driven scoreboard of DO, DRDY and register outputs.
module tb_dyn_reconf_drp;

    logic dclk;
    logic rst;
    logic pwrdwn;

    dyn_reconf_if drp_bus ();

    // Register outputs in map order: 06..15, 16, 18..1A, 28, 4E, 4F
    logic [15:0] reg_out [0:22];

    localparam logic [6:0] ADDR_TAB [0:22] = '{
        7'h06, 7'h07, 7'h08, 7'h09, 7'h0A, 7'h0B, 7'h0C, 7'h0D,
        7'h0E, 7'h0F, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15,
        7'h16, 7'h18, 7'h19, 7'h1A, 7'h28, 7'h4E, 7'h4F
    };

    dyn_reconf_drp dut (
        .DCLK       (dclk),
        .RST        (rst),
        .PWRDWN     (pwrdwn),
        .drp        (drp_bus.slave),
        .ClkReg1_0  (reg_out[2]),
        .ClkReg1_1  (reg_out[4]),
        .ClkReg1_2  (reg_out[6]),
        .ClkReg1_3  (reg_out[8]),
        .ClkReg1_4  (reg_out[10]),
        .ClkReg1_5  (reg_out[0]),
        .ClkReg1_6  (reg_out[12]),
        .ClkReg1_FB (reg_out[14]),
        .ClkReg2_0  (reg_out[3]),
        .ClkReg2_1  (reg_out[5]),
        .ClkReg2_2  (reg_out[7]),
        .ClkReg2_3  (reg_out[9]),
        .ClkReg2_4  (reg_out[11]),
        .ClkReg2_5  (reg_out[1]),
        .ClkReg2_6  (reg_out[13]),
        .ClkReg2_FB (reg_out[15]),
        .DivReg     (reg_out[16]),
        .LockReg1   (reg_out[17]),
        .LockReg2   (reg_out[18]),
        .LockReg3   (reg_out[19]),
        .FiltReg1   (reg_out[21]),
        .FiltReg2   (reg_out[22]),
        .PowerReg   (reg_out[20])
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] mdl_regs [0:22];
    logic [15:0] mdl_do;
    logic        mdl_drdy;
    logic [15:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 16'h%04h, expected 16'h%04h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int find_idx(input logic [6:0] addr);
        for (int i = 0; i < 23; i++) begin
            if (ADDR_TAB[i] == addr) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 23; i++) mdl_regs[i] = 16'h0000;
        mdl_do   = 16'h0000;
        mdl_drdy = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 23; i++) begin
            check_eq($sformatf("%s_reg%02h", tag, ADDR_TAB[i]), reg_out[i], mdl_regs[i]);
        end
    endtask

    // Drives one edge's worth of inputs from a negedge, predicts, then checks at the next negedge
    task automatic drp_cycle(input string tag, input logic en, input logic we, input logic pd,
                             input logic [6:0] addr, input logic [15:0] di);
        int k;
        drp_bus.DEN   = en;
        drp_bus.DWE   = we;
        drp_bus.DADDR = addr;
        drp_bus.DI    = di;
        pwrdwn        = pd;
        k = find_idx(addr);
        if (pd) begin
            mdl_drdy = 1'b0;
        end else if (en) begin
            mdl_drdy = 1'b0;
            if (we) begin
                if (k >= 0) mdl_regs[k] = di;
            end else begin
                mdl_do = (k >= 0) ? mdl_regs[k] : 16'h0000;
            end
        end else begin
            mdl_drdy = 1'b1;
        end
        exp_q.push_back(mdl_do);
        @(posedge dclk);
        @(negedge dclk);
        check_eq({tag, "_DO"}, drp_bus.DO, exp_q.pop_front());
        check_eq({tag, "_DRDY"}, {15'd0, drp_bus.DRDY}, {15'd0, mdl_drdy});
    endtask

    initial begin
        rst           = 1'b0;
        pwrdwn        = 1'b0;
        drp_bus.DEN   = 1'b0;
        drp_bus.DWE   = 1'b0;
        drp_bus.DADDR = 7'h00;
        drp_bus.DI    = 16'h0000;
        model_reset();

        // Reset held for two cycles
        repeat (2) @(negedge dclk);
        check_eq("rst_DO", drp_bus.DO, 16'h0000);
        check_eq("rst_DRDY", {15'd0, drp_bus.DRDY}, 16'h0000);
        check_regs("rst");

        rst = 1'b1;
        drp_cycle("idle0", 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000);

        // Basic write / idle / read of ClkReg1_0
        drp_cycle("wr08", 1'b1, 1'b1, 1'b0, 7'h08, 16'h9999);
        check_eq("wr08_ClkReg1_0", reg_out[2], 16'h9999);
        drp_cycle("idle1", 1'b0, 1'b0, 1'b0, 7'h08, 16'h0000);
        drp_cycle("rd08", 1'b1, 1'b0, 1'b0, 7'h08, 16'h0000);
        check_eq("rd08_val", drp_bus.DO, 16'h9999);

        // Unmapped address: write ignored, read returns zero
        drp_cycle("idle2", 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000);
        drp_cycle("wr7F", 1'b1, 1'b1, 1'b0, 7'h7F, 16'h1234);
        drp_cycle("idle3", 1'b0, 1'b0, 1'b0, 7'h7F, 16'h0000);
        drp_cycle("rd7F", 1'b1, 1'b0, 1'b0, 7'h7F, 16'h0000);
        check_eq("rd7F_val", drp_bus.DO, 16'h0000);
        check_regs("unm");

        // Power-down blocks the write to PowerReg and holds DRDY low
        drp_cycle("pd_wr28", 1'b1, 1'b1, 1'b1, 7'h28, 16'hFFFF);
        check_eq("pd_PowerReg", reg_out[20], 16'h0000);
        drp_cycle("pd_rd08", 1'b1, 1'b0, 1'b1, 7'h08, 16'h0000);
        drp_cycle("pd_idle", 1'b0, 1'b0, 1'b1, 7'h00, 16'h0000);
        drp_cycle("pd_exit", 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000);

        // Fill every mapped register with an address-derived pattern, then read all back
        for (int i = 0; i < 23; i++) begin
            drp_cycle("fill", 1'b1, 1'b1, 1'b0, ADDR_TAB[i], {ADDR_TAB[i], 9'h0A5} ^ 16'h5A00);
            drp_cycle("fill_idle", 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000);
        end
        check_regs("fill");
        for (int i = 22; i >= 0; i--) begin
            drp_cycle("rback", 1'b1, 1'b0, 1'b0, ADDR_TAB[i], 16'h0000);
        end
        drp_cycle("gap_rd17", 1'b1, 1'b0, 1'b0, 7'h17, 16'h0000);
        drp_cycle("gap_rd00", 1'b1, 1'b0, 1'b0, 7'h00, 16'h0000);
        drp_cycle("idle4", 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000);

        // DEN held high: write then read of same address on consecutive edges
        drp_cycle("hold_wr4F", 1'b1, 1'b1, 1'b0, 7'h4F, 16'hBEEF);
        drp_cycle("hold_rd4F", 1'b1, 1'b0, 1'b0, 7'h4F, 16'h0000);
        check_eq("hold_rd4F_val", drp_bus.DO, 16'hBEEF);
        drp_cycle("hold_wr06", 1'b1, 1'b1, 1'b0, 7'h06, 16'h0001);
        drp_cycle("hold_rd06", 1'b1, 1'b0, 1'b0, 7'h06, 16'h0000);
        drp_cycle("idle5", 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000);

        // Random mix of accesses over mapped and unmapped addresses
        for (int n = 0; n < 40; n++) begin
            logic [6:0] ra;
            ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : ADDR_TAB[$urandom_range(0, 22)];
            drp_cycle("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 9) == 0), ra, 16'($urandom));
        end
        drp_cycle("idle6", 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000);
        check_regs("rnd");

        // Asynchronous reset mid-transaction
        drp_bus.DEN   = 1'b1;
        drp_bus.DWE   = 1'b0;
        drp_bus.DADDR = 7'h4F;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_eq("arst_DO", drp_bus.DO, 16'h0000);
        check_eq("arst_DRDY", {15'd0, drp_bus.DRDY}, 16'h0000);
        check_regs("arst");
        @(negedge dclk);
        rst = 1'b1;
        drp_cycle("post_rst", 1'b0, 1'b0, 1'b0, 7'h00, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
